ls_control_unit: RTL and testbench
==================================

// Module: ls_control_unit
// PURPOSE
//  Upstream control stage for the load/store register-file datapath (rf).
//  Accepts 32-bit RV64I instructions via valid/ready, decodes LD/SD, builds
//  the sign-extended 64-bit offset, drives rf (enable, load_store, a, b, w, din)
//  for MEM_LAT cycles, then reports completion. One instruction in flight.
// PARAMETERS
//  INSTR_W  32  instruction width
//  DATA_W   64  datapath width (rf_din, immediate after sign extension)
//  REG_AW   5   register index width
//  MEM_LAT  1   cycles rf_enable is held per operation (>=1)
// PORTS
//  clk            in   1        rising-edge clock, the only clock
//  rst_n          in   1        asynchronous, active-low reset
//  instr_valid    in   1        instr holds a valid instruction
//  instr          in   INSTR_W  RV64I instruction word
//  instr_ready    out  1        unit can accept an instruction (IDLE only)
//  rf_enable      out  1        rf operation strobe
//  rf_load_store  out  1        1 = LD (mem->reg[w]), 0 = SD (reg[a]->mem)
//  rf_a           out  REG_AW   store-data register (rs2)
//  rf_b           out  REG_AW   base register (rs1)
//  rf_w           out  REG_AW   load destination register (rd)
//  rf_din         out  DATA_W   sign-extended offset
//  done           out  1        1-cycle pulse: instruction retired
//  illegal        out  1        1-cycle pulse: instruction not LD/SD
//  op_count       out  16       retired LD/SD count, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output 0 except instr_ready=1;
//   MEM_LAT counter 0. Reset mid-operation abandons the op: no done, no count.
//  FSM IDLE->DECODE->EXEC->DONE->IDLE:
//   IDLE: instr_ready=1; on instr_valid&&instr_ready capture instr -> DECODE.
//   DECODE: LD = opcode 7'b0000011 & funct3 3'b011; SD = 7'b0100011 & 3'b011.
//    Else pulse illegal, -> IDLE. Legal: load rf_b=instr[19:15],
//    rf_a=instr[24:20], rf_w=instr[11:7], rf_load_store=(LD);
//    rf_din = sext(instr[31:20]) for LD, sext({instr[31:25],instr[11:7]}) for SD.
//    LD with rd=x0: skip EXEC (no rf_enable), -> DONE.
//   EXEC: rf_enable=1 for exactly MEM_LAT cycles (down-counter), then -> DONE.
//   DONE: done=1 one cycle, op_count+1 (mod 2^16), -> IDLE.
//  rf_a/b/w/din/load_store registered; stable from DECODE exit through EXEC;
//   hold last value afterwards. instr ignored unless IDLE.
//  Latency: accept edge N -> rf_enable N+2..N+1+MEM_LAT -> done cycle N+2+MEM_LAT.
//  Back-to-back: next accept earliest the cycle after done (instr_ready=1).
// CONFIGURATION
//  LSCU_ILLEGAL_TRAP_EN defined: illegal instruction also sets sticky trap;
//   instr_ready stays 0 (unit halted) until rst_n; illegal stays asserted.
//  Not defined: illegal is a 1-cycle pulse; unit returns to IDLE and continues.
// STRUCTURE
//  ls_ctrl_defs.vh: opcode/funct3 constants, FSM state encodings (2-bit).
//  Sub-module ls_imm_gen: combinational I/S-type immediate select + sign-extend
//   to DATA_W. FSM, counters, output registers in ls_control_unit.
// TESTING
//  1 SD x4,2(x6) = 32'h00433123 -> rf_load_store=0, a=4, b=6, din=2,
//    rf_enable high MEM_LAT cycles, done one cycle later, op_count=1.
//  2 LD x2,3(x13) = 32'h0036B103 -> load_store=1, w=2, b=13, din=3; done.
//  3 LD x3,-8(x21) = 32'hFF8AB183 -> din=64'hFFFF_FFFF_FFFF_FFF8, w=3, b=21.
//  4 ADD = 32'h00000033 -> illegal pulse, no rf_enable, op_count unchanged;
//    with LSCU_ILLEGAL_TRAP_EN: instr_ready stays 0 until reset.
//  5 LD x0,0(x0) = 32'h00003003 -> done pulse, rf_enable never asserted.
//  6 rst_n low during EXEC -> outputs 0, instr_ready=1 at once, no done;
//    instr_valid held with ready=0 in EXEC is not consumed twice.

Source files
------------

// File: rtl/ls_control_unit_pkg.sv
// Shared constants and FSM state type for the load/store control unit.
// Build option: LSCU_ILLEGAL_TRAP_EN (see ls_control_unit.sv).
package ls_control_unit_pkg;

   // RV64I major opcodes and funct3 for the doubleword LD/SD forms
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [2:0] F3_DOUBLE = 3'b011;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StDecode = 2'd1,
      StExec   = 2'd2,
      StDone   = 2'd3
   } lscu_state_e;

   // True when the register index names the hardwired-zero register
   function automatic logic is_x0(input logic [4:0] idx);
      return idx == 5'd0;
   endfunction

endpackage

// File: rtl/ls_imm_gen.sv
// Combinational immediate builder: selects the I-type (LD) or S-type (SD)
// 12-bit offset and sign-extends it to DATA_W.
module ls_imm_gen #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned DATA_W  = 64
) (
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               is_store_i,
   output logic [DATA_W-1:0]  imm_o
);

   logic [11:0] imm12;

   // Stores split the offset around the rd field; loads keep it contiguous
   always_comb begin
      imm12 = instr_i[31:20];
      if (is_store_i) begin
         imm12 = {instr_i[31:25], instr_i[11:7]};
      end
   end

   assign imm_o = {{(DATA_W-12){imm12[11]}}, imm12};

   logic unused_bits;
   assign unused_bits = ^{instr_i[19:12], instr_i[6:0]};

endmodule

// File: rtl/ls_control_unit.sv
// Load/store control stage: accepts one RV64I instruction at a time, decodes
// LD/SD, drives the register-file port for MEM_LAT cycles, then retires it.
// Build option: LSCU_ILLEGAL_TRAP_EN makes an illegal instruction halt the
// unit (sticky illegal, instr_ready low) until rst_n.
module ls_control_unit
   import ls_control_unit_pkg::*;
#(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic               rf_enable,
   output logic               rf_load_store,
   output logic [REG_AW-1:0]  rf_a,
   output logic [REG_AW-1:0]  rf_b,
   output logic [REG_AW-1:0]  rf_w,
   output logic [DATA_W-1:0]  rf_din,
   output logic               done,
   output logic               illegal,
   output logic [15:0]        op_count
);

   // Counter holds MEM_LAT-1 down to 0, so clog2(MEM_LAT) bits suffice
   localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   lscu_state_e        state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CntW-1:0]    lat_q, lat_d;
   logic               ls_q, ls_d;
   logic [REG_AW-1:0]  a_q, a_d, b_q, b_d, w_q, w_d;
   logic [DATA_W-1:0]  din_q, din_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               illegal_now;

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic               is_ld, is_sd;
   logic [DATA_W-1:0]  imm;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign is_ld  = (opcode == OPC_LOAD)  && (funct3 == F3_DOUBLE);
   assign is_sd  = (opcode == OPC_STORE) && (funct3 == F3_DOUBLE);

   ls_imm_gen #(
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W)
   ) u_imm_gen (
      .instr_i    (instr_q),
      .is_store_i (is_sd),
      .imm_o      (imm)
   );

`ifdef LSCU_ILLEGAL_TRAP_EN
   logic trap_q, trap_d;

   // Sticky trap: once set, only rst_n clears it
   always_comb begin
      trap_d = trap_q | illegal_now;
   end

   // Trap flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trap_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
      end
   end

   assign instr_ready = (state_q == StIdle) && !trap_q;
   assign illegal     = illegal_now | trap_q;
`else
   assign instr_ready = (state_q == StIdle);
   assign illegal     = illegal_now;
`endif

   assign rf_enable     = (state_q == StExec);
   assign done          = (state_q == StDone);
   assign rf_load_store = ls_q;
   assign rf_a          = a_q;
   assign rf_b          = b_q;
   assign rf_w          = w_q;
   assign rf_din        = din_q;
   assign op_count      = cnt_q;

   // Next-state, capture and rf-field loading
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      lat_d       = lat_q;
      ls_d        = ls_q;
      a_d         = a_q;
      b_d         = b_q;
      w_d         = w_q;
      din_d       = din_q;
      cnt_d       = cnt_q;
      illegal_now = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (instr_valid && instr_ready) begin
               instr_d = instr;
               state_d = StDecode;
            end
         end
         StDecode: begin
            if (is_ld || is_sd) begin
               ls_d  = is_ld;
               a_d   = instr_q[24:20];
               b_d   = instr_q[19:15];
               w_d   = instr_q[11:7];
               din_d = imm;
               lat_d = CntW'(MEM_LAT - 1);
               // A load into x0 has no architectural effect: retire without rf access
               state_d = (is_ld && is_x0(instr_q[11:7])) ? StDone : StExec;
            end else begin
               illegal_now = 1'b1;
               state_d     = StIdle;
            end
         end
         StExec: begin
            if (lat_q == '0) begin
               state_d = StDone;
            end else begin
               lat_d = lat_q - CntW'(1);
            end
         end
         StDone: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         instr_q <= '0;
         lat_q   <= '0;
         ls_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         w_q     <= '0;
         din_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         lat_q   <= lat_d;
         ls_q    <= ls_d;
         a_q     <= a_d;
         b_q     <= b_d;
         w_q     <= w_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ls_control_unit.sv
// Self-checking bench for ls_control_unit: directed cases then random
// LD/SD/other instructions against a behavioural model.
module tb_ls_control_unit;

   localparam int unsigned L = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic        rf_enable;
   logic        rf_load_store;
   logic [4:0]  rf_a, rf_b, rf_w;
   logic [63:0] rf_din;
   logic        done;
   logic        illegal;
   logic [15:0] op_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_count = 16'd0;

   always #5 clk = ~clk;

   ls_control_unit #(
      .INSTR_W (32),
      .DATA_W  (64),
      .REG_AW  (5),
      .MEM_LAT (L)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_ready   (instr_ready),
      .rf_enable     (rf_enable),
      .rf_load_store (rf_load_store),
      .rf_a          (rf_a),
      .rf_b          (rf_b),
      .rf_w          (rf_w),
      .rf_din        (rf_din),
      .done          (done),
      .illegal       (illegal),
      .op_count      (op_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 0 = not LD/SD, 1 = LD, 2 = SD
   function automatic int classify(input logic [31:0] iw);
      if (iw[6:0] == 7'h03 && iw[14:12] == 3'd3) return 1;
      if (iw[6:0] == 7'h23 && iw[14:12] == 3'd3) return 2;
      return 0;
   endfunction

   function automatic logic [63:0] model_imm(input logic [31:0] iw, input int kind);
      longint s;
      s = longint'($signed(iw));
      if (kind == 2) return 64'(((s >>> 25) <<< 5) + longint'({59'd0, iw[11:7]}));
      return 64'(s >>> 20);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 64'(instr_ready), 64'd1);
      chk("rst_outs", 64'({rf_enable, rf_load_store, done, illegal}), 64'd0);
      chk("rst_fields", 64'({rf_a, rf_b, rf_w}) | rf_din | 64'(op_count), 64'd0);
      exp_count = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one instruction at a negedge and check the whole transaction.
   // instr_valid is held through the busy period to show it is not re-accepted.
   task automatic issue(input logic [31:0] iw);
      int          kind, w, drop_k;
      logic [63:0] imm;
      logic [15:0] en_m, done_m, ill_m, rdy_m, xen, xdone, xill, xrdy;
      logic        trap;
      kind = classify(iw);
      imm  = model_imm(iw, kind);
      trap = 1'b0;
`ifdef LSCU_ILLEGAL_TRAP_EN
      trap = (kind == 0);
`endif
      w = 0;
      while (!instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", 64'(instr_ready), 64'd1);
      xen = '0; xdone = '0; xill = '0; xrdy = '0;
      en_m = '0; done_m = '0; ill_m = '0; rdy_m = '0;
      if (kind == 0) begin
         drop_k = 1;
         for (int k = 1; k <= int'(L) + 4; k++) begin
            if (k == 1 || trap) xill[k] = 1'b1;
            if (k >= 2 && !trap) xrdy[k] = 1'b1;
         end
      end else if (kind == 1 && iw[11:7] == 5'd0) begin
         drop_k = 2;
         xdone[2] = 1'b1;
         for (int k = 3; k <= int'(L) + 4; k++) xrdy[k] = 1'b1;
      end else begin
         drop_k = int'(L) + 2;
         for (int k = 2; k <= int'(L) + 1; k++) xen[k] = 1'b1;
         xdone[L+2] = 1'b1;
         for (int k = int'(L) + 3; k <= int'(L) + 4; k++) xrdy[k] = 1'b1;
      end
      instr       = iw;
      instr_valid = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= int'(L) + 4; k++) begin
         en_m[k]   = rf_enable;
         done_m[k] = done;
         ill_m[k]  = illegal;
         rdy_m[k]  = instr_ready;
         if (k == 2 && kind != 0) begin
            chk("rf_load_store", 64'(rf_load_store), (kind == 1) ? 64'd1 : 64'd0);
            chk("rf_a", 64'(rf_a), 64'(iw[24:20]));
            chk("rf_b", 64'(rf_b), 64'(iw[19:15]));
            chk("rf_w", 64'(rf_w), 64'(iw[11:7]));
            chk("rf_din", rf_din, imm);
         end
         if (k == drop_k) begin
            instr_valid = 1'b0;
            instr       = $urandom;
         end
         @(negedge clk);
      end
      chk("en_pattern", 64'(en_m), 64'(xen));
      chk("done_pattern", 64'(done_m), 64'(xdone));
      chk("illegal_pattern", 64'(ill_m), 64'(xill));
      chk("ready_pattern", 64'(rdy_m), 64'(xrdy));
      if (kind != 0) exp_count = exp_count + 16'd1;
      chk("op_count", 64'(op_count), 64'(exp_count));
      if (trap) do_reset();
   endtask

   initial begin
      logic [31:0] iw;
      logic [15:0] seen;
      int          kind;
      instr_valid = 1'b0;
      instr       = 32'd0;
      rst_n       = 1'b0;
      #1;
      @(negedge clk);
      do_reset();

      issue(32'h00433123);  // SD x4,2(x6)
      issue(32'h0036B103);  // LD x2,3(x13)
      issue(32'hFF8AB183);  // LD x3,-8(x21)
      chk("ld_neg_din", rf_din, 64'hFFFF_FFFF_FFFF_FFF8);
      issue(32'h00000033);  // ADD
      issue(32'h00003003);  // LD x0,0(x0)
      issue(32'hFE533C23);  // SD x5,-8(x6)

      // Reset in the middle of EXEC abandons the operation
      instr       = 32'h00433123;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      chk("exec_before_rst", 64'(rf_enable), 64'd1);
      #2;
      do_reset();
      seen = '0;
      for (int k = 0; k < 6; k++) begin
         seen[k] = done | rf_enable;
         @(negedge clk);
      end
      chk("no_done_after_rst", 64'(seen), 64'd0);
      chk("count_after_rst", 64'(op_count), 64'd0);

      // Random mix
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 2));
         iw   = $urandom;
         if (kind == 1) begin
            iw[6:0] = 7'h03; iw[14:12] = 3'd3;
            if ($urandom_range(0, 5) == 0) iw[11:7] = 5'd0;
         end else if (kind == 2) begin
            iw[6:0] = 7'h23; iw[14:12] = 3'd3;
         end else begin
            while (classify(iw) != 0) iw = $urandom;
         end
         issue(iw);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
